apb_ram_ctrl: RTL
=================

Name: apb_ram_ctrl

Overview:
- APB slave controller that sequences the dual-port RAM (write port A, registered-read port B) for a single APB master.
- Decodes the byte address and maps PSTRB onto RAM byte lanes.
- Inserts one wait state on reads to cover the RAM's 1-cycle registered read.
- Sits between the APB interconnect and the RAM; the integration wrapper drives the RAM's active-low resetn from the inverse of reset.

Parameters:
- DATA_WIDTH, 32: APB and RAM data width; only 32 is supported.
- DEPTH, 1024: RAM depth in words.
- ADDR_WIDTH, $clog2(DEPTH): RAM word-address width.
- PADDR_WIDTH, 32: APB byte-address width.
- BYTE_LANE, DATA_WIDTH/8: number of strobe bits and RAM byte lanes.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  PADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  BYTE_LANE  write byte strobes.
- pready  out  1  transfer complete.
- prdata  out  DATA_WIDTH  read data.
- pslverr  out  1  transfer error.
- ram_write_a  out  1  RAM port-A write enable.
- ram_addr_a  out  ADDR_WIDTH  RAM write word address.
- ram_byte_sel  out  BYTE_LANE  RAM byte enables.
- ram_datain_a  out  DATA_WIDTH  RAM write data.
- ram_read_b  out  1  RAM port-B read enable.
- ram_addr_b  out  ADDR_WIDTH  RAM read word address.
- ram_dataout_b  in  DATA_WIDTH  RAM read data; valid one cycle after ram_addr_b is driven with ram_read_b=1, and zero whenever ram_write_a=1.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset state: FSM in IDLE; pready=0, pslverr=0, prdata=0, ram_write_a=0, ram_read_b=0, ram_byte_sel=0; address and data registers cleared to 0.
- Address decode: word index = paddr[ADDR_WIDTH+1:2].
  - Out of range = any of paddr[PADDR_WIDTH-1:ADDR_WIDTH+2] set.
  - Misaligned = paddr[1:0] != 0.
- FSM states: IDLE, WRITE, RD_REQ, RD_DATA, ERR.
- IDLE:
  - On psel=1 and penable=0 (setup phase), register the word index, pwdata and pstrb.
  - Next state is ERR if an error is decoded (feature enabled), else WRITE if pwrite=1, else RD_REQ.
- WRITE (access cycle):
  - ram_write_a=1, ram_byte_sel=registered pstrb, pready=1.
  - The RAM commits at this cycle's closing edge; next state IDLE.
  - Write latency: 0 wait states.
- RD_REQ:
  - ram_read_b=1, ram_addr_b=word index, ram_write_a=0, pready=0.
  - Next state RD_DATA.
- RD_DATA:
  - ram_read_b=1, ram_addr_b held; prdata=ram_dataout_b (combinational); pready=1.
  - Next state IDLE.
  - Read latency: 1 wait state.
- ERR: pready=1, pslverr=1, prdata=0, no RAM strobe; next state IDLE.
- Outside RD_DATA, prdata=0. ram_write_a and ram_read_b are never high in the same cycle. ram_byte_sel=0 except in WRITE.
- pstrb=0 on a write: completes normally with pready=1 and no byte modified.
- psel deasserted in any non-IDLE state (protocol violation): return to IDLE next edge, drop all strobes, no write committed if the drop occurs before WRITE.
- Back-to-back transfers: after completion the FSM is in IDLE in time to sample the next setup phase; no idle cycle is inserted beyond the APB setup phase.
- Reset mid-transfer: immediate return to IDLE and all strobes low; an in-flight write is not committed unless its closing edge precedes reset assertion.

Optional Feature:
- Macro: APB_RAM_CTRL_PSLVERR_EN.
- Defined: out-of-range or misaligned addresses go to ERR (pslverr=1, no RAM access).
- Undefined:
  - pslverr is tied to 0 and the ERR state is absent.
  - Upper and low address bits are ignored, so the address wraps modulo DEPTH words.

Decomposition:
- Package apb_ram_pkg contains:
  - the FSM state enum typedef;
  - the PADDR_WIDTH default;
  - the function addr_err(paddr), returning the out-of-range / misaligned flag;
  - the function word_idx(paddr).
- No sub-module: the decode is a package function.
- A separate wrapper, apb_ram_top, instantiates apb_ram_ctrl plus the RAM; the wrapper is out of this block's scope.

Test Plan:
- Write then read: write paddr=0x10, pwdata=0xDEADBEEF, pstrb=4'hF, then read 0x10 -> write pready on its first access cycle; read pready after 1 wait state; prdata=0xDEADBEEF.
- Partial write: write 0x20=0x11223344 (strb F), then 0x20=0xAABBCCDD with strb 4'b0101, then read 0x20 -> prdata=0x11BB33DD.
- Back-to-back: writes to 0x0/0x4/0x8 = 1/2/3, then reads in the same order -> 1, 2, 3; ram_write_a and ram_read_b never high together.
- Error (macro defined): read 0x1000 and write 0x6 -> pslverr=1, pready=1, prdata=0, ram_write_a stays 0. Undefined: the write to 0x1000 lands at word 0, readback from 0x0 matches.
- Reset mid-read: assert reset in RD_REQ -> outputs go to reset values immediately; after release, a read of 0x10 returns the previously written value.
- Zero strobe: write 0x30=0xFFFFFFFF with pstrb=0 after 0x30=0x12345678 -> pready=1; readback 0x12345678.

Source files
------------

// File: rtl/apb_ram_pkg.sv
// -----------------------------------------------------------------------------
// apb_ram_pkg
// Shared definitions for the APB RAM controller:
//   - state_t         : controller FSM state encoding
//   - APB_PADDR_WIDTH : default APB byte-address width
//   - addr_err()      : out-of-range / misaligned byte-address flag
//   - word_idx()      : byte address -> RAM word index (wraps modulo depth)
// Optional feature macro: APB_RAM_CTRL_PSLVERR_EN (adds the ERR state).
// -----------------------------------------------------------------------------
package apb_ram_pkg;

   localparam int APB_PADDR_WIDTH = 32;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      RD_REQ,
      RD_DATA
`ifdef APB_RAM_CTRL_PSLVERR_EN
      ,ERR
`endif
   } state_t;

   // Set when the address is not word aligned or when any bit above the
   // RAM word-index field is set. aw is the RAM word-address width.
   function automatic logic addr_err(input logic [APB_PADDR_WIDTH-1:0] paddr,
                                     input int                         aw);
      logic [APB_PADDR_WIDTH-1:0] upper;
      upper = paddr >> (aw + 2);
      return (paddr[1:0] != 2'b00) || (upper != '0);
   endfunction

   // Word index is paddr[aw+1:2]; everything else is discarded, so an
   // unchecked address simply wraps around the RAM.
   function automatic logic [APB_PADDR_WIDTH-1:0] word_idx(
      input logic [APB_PADDR_WIDTH-1:0] paddr,
      input int                         aw);
      logic [APB_PADDR_WIDTH-1:0] mask;
      mask = (APB_PADDR_WIDTH'(1) << aw) - APB_PADDR_WIDTH'(1);
      return (paddr >> 2) & mask;
   endfunction

endpackage

// File: rtl/apb_ram_ctrl.sv
// -----------------------------------------------------------------------------
// apb_ram_ctrl
// APB slave that sequences a dual-port RAM (port A: write, port B: registered
// read). Writes complete with no wait state, reads with one wait state to
// cover the RAM's registered read.
//
// Optional feature macro: APB_RAM_CTRL_PSLVERR_EN
//   defined   : misaligned / out-of-range addresses complete through ERR with
//               pslverr=1 and no RAM access.
//   undefined : pslverr tied low, address wraps modulo DEPTH words.
//
// Ports:
//   clk, reset                : clock, asynchronous active-high reset
//   psel, penable, pwrite     : APB control
//   paddr, pwdata, pstrb      : APB byte address, write data, byte strobes
//   pready, prdata, pslverr   : APB response
//   ram_write_a, ram_addr_a,
//   ram_byte_sel, ram_datain_a: RAM write port A
//   ram_read_b, ram_addr_b    : RAM read port B request
//   ram_dataout_b             : RAM read data (valid one cycle after request)
// -----------------------------------------------------------------------------
module apb_ram_ctrl
   import apb_ram_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 1024,
   parameter int ADDR_WIDTH  = $clog2(DEPTH),
   parameter int PADDR_WIDTH = APB_PADDR_WIDTH,
   parameter int BYTE_LANE   = DATA_WIDTH / 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   psel,
   input  logic                   penable,
   input  logic                   pwrite,
   input  logic [PADDR_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0]  pwdata,
   input  logic [BYTE_LANE-1:0]   pstrb,
   output logic                   pready,
   output logic [DATA_WIDTH-1:0]  prdata,
   output logic                   pslverr,
   output logic                   ram_write_a,
   output logic [ADDR_WIDTH-1:0]  ram_addr_a,
   output logic [BYTE_LANE-1:0]   ram_byte_sel,
   output logic [DATA_WIDTH-1:0]  ram_datain_a,
   output logic                   ram_read_b,
   output logic [ADDR_WIDTH-1:0]  ram_addr_b,
   input  logic [DATA_WIDTH-1:0]  ram_dataout_b
);

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic [ADDR_WIDTH-1:0]   addr_next;
   logic                    setup;

   assign setup     = psel && !penable;
   assign addr_next = ADDR_WIDTH'(word_idx(paddr, ADDR_WIDTH));

   // One registered word index serves both ports: only one of them is ever
   // strobed in a given cycle.
   assign ram_addr_a   = addr_q;
   assign ram_addr_b   = addr_q;
   assign ram_datain_a = data_q;

   // NOTE: prdata is combinational from the RAM output so the registered read
   // data reaches the bus in the same cycle it becomes valid (RD_DATA); it is
   // forced to zero elsewhere so stale RAM output never leaks onto the bus.
   assign prdata = (state == RD_DATA) ? ram_dataout_b : '0;

`ifdef APB_RAM_CTRL_PSLVERR_EN
   logic pslverr_q;
   logic err_next;
   assign err_next = addr_err(paddr, ADDR_WIDTH);
   assign pslverr  = pslverr_q;
`else
   assign pslverr  = 1'b0;
`endif

   // Every output strobe is registered and set on the edge that enters the
   // state owning it, so each state's outputs are valid for its whole cycle.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register sees the pre-edge value of every other register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: every control and datapath register here is reset; the RAM
         // array itself lives outside this block and is never cleared.
         state        <= IDLE;
         pready       <= 1'b0;
         ram_write_a  <= 1'b0;
         ram_read_b   <= 1'b0;
         ram_byte_sel <= '0;
         addr_q       <= '0;
         data_q       <= '0;
`ifdef APB_RAM_CTRL_PSLVERR_EN
         pslverr_q    <= 1'b0;
`endif
      end else begin
         // Strobes default low; each branch raises only what the next state
         // needs. This also drops everything when psel is withdrawn.
         pready       <= 1'b0;
         ram_write_a  <= 1'b0;
         ram_read_b   <= 1'b0;
         ram_byte_sel <= '0;
`ifdef APB_RAM_CTRL_PSLVERR_EN
         pslverr_q    <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (setup) begin
                  addr_q <= addr_next;
                  data_q <= pwdata;
`ifdef APB_RAM_CTRL_PSLVERR_EN
                  if (err_next) begin
                     state     <= ERR;
                     pready    <= 1'b1;
                     pslverr_q <= 1'b1;
                  end else
`endif
                  if (pwrite) begin
                     state        <= WRITE;
                     pready       <= 1'b1;
                     ram_write_a  <= 1'b1;
                     ram_byte_sel <= pstrb;
                  end else begin
                     state      <= RD_REQ;
                     ram_read_b <= 1'b1;
                  end
               end
            end

            // RAM commits at the closing edge of this access cycle.
            WRITE: state <= IDLE;

            // The wait state: RAM is sampling the address this cycle.
            RD_REQ: begin
               if (psel) begin
                  state      <= RD_DATA;
                  ram_read_b <= 1'b1;
                  pready     <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end

            RD_DATA: state <= IDLE;

`ifdef APB_RAM_CTRL_PSLVERR_EN
            ERR: state <= IDLE;
`endif

            default: state <= IDLE;
         endcase
      end
   end

endmodule
